// File: rtl/legv8_rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
`ifndef WORD
`define WORD 64
`endif

package legv8_rf_pkg;

  // Default architectural zero register (XZR).
  localparam int ZERO_REG_DEF = 31;

  // Upper bounds the helpers are sized for. The instances check their
  // parameters against these at elaboration time.
  localparam int MAX_PORTS = 32;
  localparam int MAX_DEPTH = 256;

  // Index of the highest set bit of a per-port hit vector. The highest
  // port wins a same-register conflict. Returns 0 when nothing hits, so
  // callers must qualify the result with |hits.
  function automatic int unsigned hi_idx(input logic [MAX_PORTS-1:0] hits);
    int unsigned r;
    r = 0;
    for (int unsigned j = 0; j < MAX_PORTS; j++)
      if (hits[j]) r = j;
    return r;
  endfunction

  // Population count of a zero-extended busy vector.
  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++)
      c += {31'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Busy scoreboard: one bit per architectural register, plus a registered count.
module rf_scoreboard
  import legv8_rf_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rsv_valid_i,
  input  logic [AW-1:0]    rsv_reg_i,
  input  logic [DEPTH-1:0] wr_clr_i,
  output logic [DEPTH-1:0] busy_o,
  output logic [AW:0]      busy_cnt_o
);

  localparam int CW = AW + 1;

  logic [DEPTH-1:0] busy_q, busy_d, rsv_set;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Decode the reservation. Out-of-range indices match no row, and XZR is
  // never reserved. A reservation wins over a same-cycle clearing write.
  always_comb begin
    rsv_set = '0;
    for (int i = 0; i < DEPTH; i++)
      rsv_set[i] = rsv_valid_i && (rsv_reg_i == AW'(i)) &&
                   !((ZERO_EN != 0) && (i == ZERO_REG));
    busy_d = (busy_q & ~wr_clr_i) | rsv_set;
    cnt_d  = CW'(popcount(MAX_DEPTH'(busy_d)));
  end

  // Busy bits and their count update together, so the count always matches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-to-read bypass and busy scoreboard.
`ifndef WORD
`define WORD 64
`endif

module reg_file_mp
  import legv8_rf_pkg::*;
#(
  parameter int WIDTH    = `WORD,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_REG = ZERO_REG_DEF,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_RD*AW-1:0]    r_reg,
  output logic [NUM_RD*WIDTH-1:0] r_data,
  output logic [NUM_RD-1:0]       r_busy,
  input  logic [NUM_WR*AW-1:0]    w_reg,
  input  logic [NUM_WR*WIDTH-1:0] w_data,
  input  logic [NUM_WR-1:0]       RegWrite,
  input  logic                    rsv_valid,
  input  logic [AW-1:0]           rsv_reg,
  output logic [AW:0]             busy_cnt
);

  if (NUM_RD < 1 || NUM_WR < 1) begin : g_chk_ports
    $error("reg_file_mp: NUM_RD and NUM_WR must be at least 1");
  end
  if (NUM_WR > MAX_PORTS) begin : g_chk_wr
    $error("reg_file_mp: NUM_WR exceeds MAX_PORTS");
  end
  if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_chk_depth
    $error("reg_file_mp: DEPTH out of range");
  end
  if (ZERO_REG < 0 || ZERO_REG >= DEPTH) begin : g_chk_zero
    $error("reg_file_mp: ZERO_REG must be below DEPTH");
  end

  logic [WIDTH-1:0]              regs_q [DEPTH];
  logic [DEPTH-1:0][NUM_WR-1:0]  wr_hit;
  logic [DEPTH-1:0]              wr_en;
  logic [DEPTH-1:0][WIDTH-1:0]   wr_dat;
  logic [DEPTH-1:0]              busy;

  // Per-register write resolution. Indices past DEPTH match no row and
  // are dropped. Writes to XZR are discarded.
  always_comb begin
    int unsigned sel;
    sel    = 0;
    wr_hit = '0;
    wr_en  = '0;
    wr_dat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < NUM_WR; j++)
        wr_hit[i][j] = RegWrite[j] && (w_reg[j*AW +: AW] == AW'(i));
      sel       = hi_idx(MAX_PORTS'(wr_hit[i]));
      wr_en[i]  = (|wr_hit[i]) && !((ZERO_EN != 0) && (i == ZERO_REG));
      wr_dat[i] = w_data[sel*WIDTH +: WIDTH];
    end
  end

  // Storage array. The reset is asynchronous, so it also aborts an
  // in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_en[i]) regs_q[i] <= wr_dat[i];
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_EN  (ZERO_EN),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rsv_valid_i (rsv_valid),
    .rsv_reg_i   (rsv_reg),
    .wr_clr_i    (wr_en),
    .busy_o      (busy),
    .busy_cnt_o  (busy_cnt)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]     idx;
    logic [NUM_WR-1:0] byp_hit;
    logic [WIDTH-1:0]  arr, dat;
    logic              in_rng, is_zero, bsy, bsy_o;

    assign idx = r_reg[k*AW +: AW];

    // Read mux with write-first bypass. XZR and out-of-range indices read
    // 0, and everything reads 0 while reset is held. A bypassed register
    // is not reported busy, because its value is already on the port.
    always_comb begin
      byp_hit = '0;
      for (int j = 0; j < NUM_WR; j++)
        byp_hit[j] = RegWrite[j] && (w_reg[j*AW +: AW] == idx);
      arr    = '0;
      bsy    = 1'b0;
      in_rng = 1'b0;
      for (int i = 0; i < DEPTH; i++)
        if (idx == AW'(i)) begin
          arr    = regs_q[i];
          bsy    = busy[i];
          in_rng = 1'b1;
        end
      is_zero = (ZERO_EN != 0) && (idx == AW'(ZERO_REG));
      dat     = '0;
      bsy_o   = 1'b0;
      if (rst_n && in_rng && !is_zero) begin
        dat   = (|byp_hit) ? w_data[hi_idx(MAX_PORTS'(byp_hit))*WIDTH +: WIDTH] : arr;
        bsy_o = bsy && !(|byp_hit);
      end
    end

    assign r_data[k*WIDTH +: WIDTH] = dat;
    assign r_busy[k]                = bsy_o;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the single-write, dual-read register file.
- Configurable word width, depth, read and write port counts, and an optional hard-wired zero register (XZR).
- Adds write-to-read bypass and a per-register busy scoreboard for multi-cycle producers such as loads and a future multiplier.
- Sits in the decode stage of the pipelined core.

Parameters:
- WIDTH, 64 (`WORD): data width of each register.
- DEPTH, 32: number of architectural registers.
- NUM_RD, 2: number of read ports.
- NUM_WR, 1: number of write ports.
- ZERO_EN, 1: when 1, register ZERO_REG is hard-wired to zero.
- ZERO_REG, 31: index of the zero register (XZR).
- AW, $clog2(DEPTH): register index width. Derived; do not override.

Ports:
- clk  in  1  system clock; rising edge active.
- rst_n  in  1  asynchronous active-low reset.
- r_reg  in  NUM_RD*AW  read register indices, port k at bits [k*AW +: AW].
- r_data  out  NUM_RD*WIDTH  read data, port k at bits [k*WIDTH +: WIDTH].
- r_busy  out  NUM_RD  indexed register has a pending reservation.
- w_reg  in  NUM_WR*AW  write register indices.
- w_data  in  NUM_WR*WIDTH  write data.
- RegWrite  in  NUM_WR  per-port write enable.
- rsv_valid  in  1  reserve a destination register (mark it busy).
- rsv_reg  in  AW  register to reserve.
- busy_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Reset:
  - Asynchronous on rst_n low; takes effect immediately, including mid-write.
  - All registers clear to 0, all busy bits to 0, busy_cnt to 0.
  - While rst_n is low: r_data = 0 and r_busy = 0 on every port.
- Write:
  - Occurs on the rising clk edge when RegWrite[j] = 1.
  - If several ports target the same register in one cycle, the highest-index port wins.
  - Writes to ZERO_REG are discarded when ZERO_EN = 1.
- Read:
  - Combinational, zero latency.
  - Bypass: if any enabled write port targets r_reg[k] this cycle, r_data[k] = that w_data (write-first; highest-index write port on conflict). Otherwise r_data[k] = array contents.
  - r_reg[k] == ZERO_REG with ZERO_EN = 1 gives r_data = 0, overriding bypass.
- Scoreboard:
  - busy[rsv_reg] sets on the clock edge when rsv_valid = 1.
  - busy[i] clears on the clock edge when any enabled write targets i.
  - Reserve and write to the same register in one cycle: busy stays 1, because the new reservation wins; the data is still written.
  - Reserving an already-busy register: no change, busy_cnt does not increment.
  - ZERO_REG is never busy; a reservation of it is ignored.
  - r_busy[k] = busy[r_reg[k]] AND NOT (an enabled write targets r_reg[k] this cycle), so the bypass resolves the hazard combinationally.
- busy_cnt:
  - Registered; equals the population count of busy after each edge.
  - Range 0..DEPTH; never wraps.
- Indices ≥ DEPTH (when DEPTH is not a power of two):
  - Reads return 0, not busy.
  - Writes and reservations are ignored.
- Elaboration checks (fail elaboration on violation):
  - NUM_RD ≥ 1, NUM_WR ≥ 1.
  - DEPTH ≥ 2.
  - ZERO_REG < DEPTH.

Decomposition:
- Package legv8_rf_pkg holds:
  - the ZERO_REG default (31);
  - the write-priority resolve function (highest-index port hit);
  - the popcount function for busy_cnt.
- WIDTH default comes from `WORD in common.vh.
- Sub-module rf_scoreboard holds the DEPTH busy bits and busy_cnt.
  - Inputs: rsv_valid, rsv_reg, and the decoded write-clear vector.
  - Output: the busy vector.
- reg_file_mp holds the storage array, write resolution, and read/bypass muxes.

Test Plan:
1. Reset, then read r_reg = {31, 30, 20} (NUM_RD = 3) → all r_data = 0, r_busy = 0, busy_cnt = 0.
2. Write reg 11 = 100 on port 0 while r_reg[0] = 11 in the same cycle → r_data[0] = 100 that cycle (bypass); next cycle, with RegWrite low, still reads 100.
3. NUM_WR = 2: port 0 writes reg 5 = 7 and port 1 writes reg 5 = 9 in one cycle → reg 5 reads 9. Write reg 31 = 123456789 → reg 31 reads 0.
4. Reserve reg 3, then reg 4 → busy_cnt = 1, then 2; r_busy for reg 3 = 1. Write reg 3 = 42 → r_busy drops in the write cycle, busy_cnt = 1 after the edge. Reserve reg 31 → busy_cnt unchanged.
5. Same cycle: reserve reg 4 and write reg 4 = 55 → reg 4 reads 55, busy stays 1, busy_cnt stays 1.
6. Write reg 1 = 123456789 and reserve reg 2, then pulse rst_n low mid-cycle → r_data = 0, busy_cnt = 0 immediately, before any clk edge; after release, reg 1 reads 0.
